// File: rtl/common_def.sv
// Shared definitions for the register write scoreboard.
package common_def;
    localparam int REG_ADDR_W    = 5;
    localparam int NUM_ARCH_REGS = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/scoreboard_counter.sv
// Saturating up/down counter that tracks outstanding writes to one register.
module scoreboard_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic nonzero,
    output logic is_one,
    output logic is_max
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // An inc and a dec in the same cycle cancel out.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && !dec && cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_ONE;
        end else if (dec && !inc && cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign nonzero = (cnt_reg != '0);
    assign is_one  = (cnt_reg == CNT_ONE);
    assign is_max  = (cnt_reg == CNT_MAX);
endmodule

// File: rtl/reg_write_scoreboard.sv
// Tracks in-flight register writes and answers RAW/WAW hazard queries for the issuing instruction.
module reg_write_scoreboard
    import common_def::*;
#(
    parameter int NUM_REGS  = NUM_ARCH_REGS,
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      issue_valid,
    input  logic      issue_we,
    input  reg_addr_t issue_rd,
    input  logic      rs1_en,
    input  logic      rs2_en,
    input  reg_addr_t rs1,
    input  reg_addr_t rs2,
    input  logic      wb_valid,
    input  reg_addr_t wb_rd,
    output logic      issue_fire,
    output logic      stall,
    output logic      rs1_busy,
    output logic      rs2_busy,
    output logic      waw_full,
    output logic      pending_any,
    output logic      underflow_err
);
    logic [NUM_REGS-1:0] nonzero;
    logic [NUM_REGS-1:0] is_one;
    logic [NUM_REGS-1:0] is_max;
    logic [NUM_REGS-1:0] issue_sel;
    logic [NUM_REGS-1:0] wb_sel;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [NUM_REGS-1:0] busy;
    logic                underflow_reg;
    logic                underflow_hit;

    // One-hot decodes; bit 0 is masked so x0 is never touched.
    always_comb begin
        issue_sel    = NUM_REGS'(1) << issue_rd;
        wb_sel       = NUM_REGS'(1) << wb_rd;
        issue_sel[0] = 1'b0;
        wb_sel[0]    = 1'b0;
    end

    assign inc_vec = (issue_fire && issue_we) ? issue_sel : '0;
    assign dec_vec = wb_valid ? (wb_sel & nonzero) : '0;

    assign nonzero[0] = 1'b0;
    assign is_one[0]  = 1'b0;
    assign is_max[0]  = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            scoreboard_counter #(
                .CNT_W (CNT_W)
            ) u_counter (
                .clk     (clk),
                .rst     (rst),
                .clr     (flush),
                .inc     (inc_vec[gi]),
                .dec     (dec_vec[gi]),
                .nonzero (nonzero[gi]),
                .is_one  (is_one[gi]),
                .is_max  (is_max[gi])
            );
        end
    endgenerate

    // A writeback retiring the last pending write makes the register readable this cycle.
    always_comb begin
        busy = nonzero;
        if (WB_BYPASS && wb_valid) begin
            busy = nonzero & ~(wb_sel & is_one);
        end
    end

    assign rs1_busy   = rs1_en & busy[rs1];
    assign rs2_busy   = rs2_en & busy[rs2];
    assign waw_full   = issue_we & (issue_rd != '0) & is_max[issue_rd];
    assign stall      = issue_valid & ~flush & (rs1_busy | rs2_busy | waw_full);
    assign issue_fire = issue_valid & ~stall & ~flush;
    assign pending_any = |nonzero;

    assign underflow_hit = wb_valid & ~flush & (wb_rd != '0) & ~nonzero[wb_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_reg <= 1'b0;
        end else if (underflow_hit) begin
            underflow_reg <= 1'b1;
        end
    end

    assign underflow_err = underflow_reg;
endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed test of reg_write_scoreboard with hand-computed expectations.
module tb_reg_write_scoreboard;
    import common_def::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      flush;
    logic      issue_valid;
    logic      issue_we;
    reg_addr_t issue_rd;
    logic      rs1_en;
    logic      rs2_en;
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      wb_valid;
    reg_addr_t wb_rd;
    logic      issue_fire;
    logic      stall;
    logic      rs1_busy;
    logic      rs2_busy;
    logic      waw_full;
    logic      pending_any;
    logic      underflow_err;

    int checks = 0;
    int errors = 0;

    reg_write_scoreboard #(
        .NUM_REGS  (32),
        .CNT_W     (2),
        .WB_BYPASS (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_we      (issue_we),
        .issue_rd      (issue_rd),
        .rs1_en        (rs1_en),
        .rs2_en        (rs2_en),
        .rs1           (rs1),
        .rs2           (rs2),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .issue_fire    (issue_fire),
        .stall         (stall),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .waw_full      (waw_full),
        .pending_any   (pending_any),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic idle();
        flush = 0; issue_valid = 0; issue_we = 0; issue_rd = '0;
        rs1_en = 0; rs2_en = 0; rs1 = '0; rs2 = '0;
        wb_valid = 0; wb_rd = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_write(input reg_addr_t rd);
        idle();
        issue_valid = 1; issue_we = 1; issue_rd = rd;
    endtask

    task automatic issue_read(input logic e1, input reg_addr_t r1, input logic e2, input reg_addr_t r2);
        idle();
        issue_valid = 1; rs1_en = e1; rs1 = r1; rs2_en = e2; rs2 = r2;
    endtask

    task automatic writeback(input reg_addr_t rd);
        idle();
        wb_valid = 1; wb_rd = rd;
    endtask

    initial begin
        idle();
        rst = 1;
        issue_valid = 1;
        #3;
        check("rst_stall", stall, 0);
        check("rst_fire_eq_valid", issue_fire, 1);
        check("rst_pending", pending_any, 0);
        check("rst_underflow", underflow_err, 0);
        @(negedge clk);
        rst = 0;
        idle();
        step();

        // RAW on x5 and same-cycle writeback bypass
        issue_write(5'd5);
        #1 check("x5_write_fire", issue_fire, 1);
        step();
        issue_read(1, 5'd5, 0, 5'd0);
        #1;
        check("x5_raw_stall", stall, 1);
        check("x5_rs1_busy", rs1_busy, 1);
        check("x5_raw_nofire", issue_fire, 0);
        check("x5_pending", pending_any, 1);
        wb_valid = 1; wb_rd = 5'd5;
        #1;
        check("x5_bypass_stall", stall, 0);
        check("x5_bypass_fire", issue_fire, 1);
        step();
        idle();
        #1 check("x5_retired_pending", pending_any, 0);

        // WAW saturation on x7
        for (int i = 0; i < 3; i++) begin
            issue_write(5'd7);
            #1 check($sformatf("x7_write%0d_fire", i), issue_fire, 1);
            step();
        end
        issue_write(5'd7);
        #1;
        check("x7_waw_full", waw_full, 1);
        check("x7_stall", stall, 1);
        check("x7_nofire", issue_fire, 0);
        wb_valid = 1; wb_rd = 5'd7;
        #1 check("x7_full_during_wb", waw_full, 1);
        step();
        wb_valid = 0;
        #1;
        check("x7_after_wb_full", waw_full, 0);
        check("x7_after_wb_fire", issue_fire, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            writeback(5'd7);
            step();
        end
        idle();
        #1;
        check("x7_drained_pending", pending_any, 0);
        check("x7_no_underflow", underflow_err, 0);

        // Simultaneous inc/dec on x9 leaves count at 1
        issue_write(5'd9);
        step();
        issue_write(5'd9);
        wb_valid = 1; wb_rd = 5'd9;
        #1 check("x9_incdec_fire", issue_fire, 1);
        step();
        issue_read(0, 5'd0, 1, 5'd9);
        #1;
        check("x9_rs2_busy", rs2_busy, 1);
        check("x9_stall", stall, 1);
        writeback(5'd9);
        step();
        idle();
        #1 check("x9_drained_pending", pending_any, 0);

        // Flush with a coincident writeback
        issue_write(5'd3);
        step();
        issue_write(5'd4);
        step();
        issue_read(1, 5'd3, 1, 5'd4);
        flush = 1; wb_valid = 1; wb_rd = 5'd3;
        #1;
        check("flush_stall_forced", stall, 0);
        check("flush_nofire", issue_fire, 0);
        step();
        flush = 0; wb_valid = 0;
        #1;
        check("flush_pending", pending_any, 0);
        check("flush_underflow", underflow_err, 0);
        check("flush_x3x4_stall", stall, 0);
        check("flush_x3x4_fire", issue_fire, 1);
        step();

        // x0 handling and underflow
        writeback(5'd0);
        step();
        idle();
        #1 check("wb_x0_no_underflow", underflow_err, 0);
        writeback(5'd12);
        step();
        idle();
        #1 check("x12_underflow_set", underflow_err, 1);
        issue_write(5'd0);
        rs1_en = 1; rs1 = 5'd0;
        #1;
        check("x0_rs1_busy", rs1_busy, 0);
        check("x0_waw_full", waw_full, 0);
        check("x0_fire", issue_fire, 1);
        step();
        idle();
        #1;
        check("x0_pending", pending_any, 0);
        check("underflow_sticky", underflow_err, 1);

        // Asynchronous reset while stalled
        issue_write(5'd20);
        step();
        issue_read(1, 5'd20, 0, 5'd0);
        #1 check("x20_stall_pre_rst", stall, 1);
        rst = 1;
        #1;
        check("async_rst_stall", stall, 0);
        check("async_rst_pending", pending_any, 0);
        check("async_rst_underflow", underflow_err, 0);
        @(negedge clk);
        rst = 0;
        step();
        #1;
        check("post_rst_stall", stall, 0);
        check("post_rst_fire", issue_fire, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
